// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- multi-cycle data-memory access controller.
//
// Sits between the core's MEM stage and a byte-addressed 128-byte data RAM.
// Accepts one load/store at a time, flags misaligned or out-of-range
// accesses, waits LATENCY cycles, drives the RAM for exactly one ACCESS cycle
// and returns the result with a one-cycle resp_valid pulse.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_we/addr/wdata   store flag, byte address, LSB-aligned store data
//   req_ubhw            size/sign code: [1]=word, [0]=half, [2]=unsigned
//   resp_valid          one-cycle response pulse
//   resp_rdata          load data (0 for stores and faults)
//   resp_fault          misaligned / out-of-range, valid with resp_valid
//   stall               req_valid & ~resp_valid, freezes the pipeline
//   ram_addr/din/ubhw   RAM port, driven from the latched request
//   ram_we              RAM write enable, high only during ACCESS
//   ram_dout            RAM combinational read data (already extended)
module dmem_ctrl #(
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_ubhw,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        stall,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   output logic        ram_we,
   output logic [2:0]  ram_ubhw,
   input  logic [31:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   localparam logic [3:0] LAT4     = 4'(LATENCY);
   localparam logic [3:0] CNT_INIT = LAT4 - 4'd1;

   state_t      state;
   logic [3:0]  cnt;
   logic        fault_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  ubhw_q;
   logic        req_fault;

   // Word takes priority over half when both size bits are set.
   always_comb begin
      req_fault = 1'b0;
      if (req_ubhw[1] && (req_addr[1:0] != 2'b00))
         req_fault = 1'b1;
      if (!req_ubhw[1] && req_ubhw[0] && req_addr[0])
         req_fault = 1'b1;
      if (req_addr[31:7] != 25'd0)
         req_fault = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         fault_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         ubhw_q     <= 3'd0;
         resp_valid <= 1'b0;
         resp_fault <= 1'b0;
         resp_rdata <= 32'd0;
         ram_we     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  ubhw_q     <= req_ubhw;
                  fault_q    <= req_fault;
                  resp_rdata <= 32'd0;   // faults respond with zero data
                  if (req_fault) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                  end else if (LATENCY > 0) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state  <= ACCESS;
                     ram_we <= req_we;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state  <= ACCESS;
                  ram_we <= we_q;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACCESS: begin
               // ram_we was high for this whole cycle: one negedge write.
               ram_we     <= 1'b0;
               resp_rdata <= we_q ? 32'd0 : ram_dout;
               resp_valid <= 1'b1;
               resp_fault <= fault_q;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign stall     = req_valid & ~resp_valid;
   assign ram_addr  = addr_q;
   assign ram_din   = wdata_q;
   assign ram_ubhw  = ubhw_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl. Four controller instances with LATENCY
// 2, 3, 0 and 15 share one behavioural 128-byte RAM; only the selected
// instance is ever given a request, so the RAM follows that instance.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rv;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_ubhw;
   logic [31:0] ram_dout;

   logic        rdy [4];
   logic        rsv [4];
   logic        rsf [4];
   logic        stl [4];
   logic        rwe [4];
   logic [31:0] rrd [4];
   logic [31:0] ra  [4];
   logic [31:0] rd  [4];
   logic [2:0]  ru  [4];

   int sel = 0;
   int nvec = 0;
   int nerr = 0;

   logic [7:0] mem [128];
   bit         mem_init_done = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dmem_ctrl #(.LATENCY(g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 0 : 15)) u_dut (
         .clk(clk), .rst(rst),
         .req_valid(rv[g]), .req_ready(rdy[g]),
         .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_ubhw(req_ubhw),
         .resp_valid(rsv[g]), .resp_rdata(rrd[g]), .resp_fault(rsf[g]), .stall(stl[g]),
         .ram_addr(ra[g]), .ram_din(rd[g]), .ram_we(rwe[g]), .ram_ubhw(ru[g]),
         .ram_dout(ram_dout)
      );
   end

   // RAM read: little-endian, extension per ubhw.
   always_comb begin
      logic [6:0]  a;
      logic [2:0]  u;
      logic [15:0] h;
      logic [7:0]  b;
      a = ra[sel][6:0];
      u = ru[sel];
      h = {mem[7'(a + 7'd1)], mem[a]};
      b = mem[a];
      ram_dout = 32'd0;
      if (u[1])
         ram_dout = {mem[7'(a + 7'd3)], mem[7'(a + 7'd2)], mem[7'(a + 7'd1)], mem[a]};
      else if (u[0])
         ram_dout = u[2] ? {16'd0, h} : {{16{h[15]}}, h};
      else
         ram_dout = u[2] ? {24'd0, b} : {{24{b[7]}}, b};
   end

   // RAM write on negedge; first negedge preloads mem[i] = i+1.
   always @(negedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 128; i++) mem[i] = 8'(i + 1);
         mem_init_done = 1'b1;
      end else if (rwe[sel]) begin
         mem[ra[sel][6:0]] = rd[sel][7:0];
         if (ru[sel][1] || ru[sel][0]) mem[7'(ra[sel][6:0] + 7'd1)] = rd[sel][15:8];
         if (ru[sel][1]) begin
            mem[7'(ra[sel][6:0] + 7'd2)] = rd[sel][23:16];
            mem[7'(ra[sel][6:0] + 7'd3)] = rd[sel][31:24];
         end
      end
   end

   // One request on instance s; returns response cycle (-1 on timeout),
   // response data/fault, whether ram_we was seen and whether stall misbehaved.
   task automatic do_req(input int s, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] u,
                         output int cyc, output logic [31:0] rdata, output logic flt,
                         output bit we_seen, output bit stall_bad);
      @(negedge clk);
      sel = s;
      req_we = we; req_addr = a; req_wdata = wd; req_ubhw = u;
      rv = 4'b0000; rv[s] = 1'b1;
      cyc = -1; rdata = 32'hx; flt = 1'bx; we_seen = 1'b0; stall_bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (rwe[s]) we_seen = 1'b1;
         if (rsv[s]) begin
            cyc = k; rdata = rrd[s]; flt = rsf[s];
            if (stl[s] !== 1'b0) stall_bad = 1'b1;
            break;
         end
         if (stl[s] !== 1'b1) stall_bad = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1 rv = 4'b0000;
   endtask

   task automatic test_reset;
      rst = 1'b1; rv = 4'b0000; req_we = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_ubhw = 3'b000;
      #2;
      for (int g = 0; g < 4; g++) begin
         nvec++;
         if ({rsv[g], rsf[g], rrd[g], rwe[g], ra[g], rd[g], ru[g], rdy[g], stl[g]} !==
             {1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL reset_state inst %0d: valid=%b fault=%b rdata=%h we=%b addr=%h din=%h ubhw=%b ready=%b stall=%b",
                     g, rsv[g], rsf[g], rrd[g], rwe[g], ra[g], rd[g], ru[g], rdy[g], stl[g]);
         end
      end
      rv = 4'b0001; #1;
      nvec++;
      if (stl[0] !== 1'b1) begin
         nerr++; $display("FAIL reset_stall: got %b want 1", stl[0]);
      end
      rv = 4'b0000;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_idle;
      // req_valid low: stay idle, nothing happens.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         nvec++;
         if (rdy[0] !== 1'b1 || rsv[0] !== 1'b0 || rwe[0] !== 1'b0) begin
            nerr++; $display("FAIL idle: ready=%b valid=%b we=%b want 1 0 0", rdy[0], rsv[0], rwe[0]);
         end
      end
   endtask

   task automatic test_word_store_load;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 4 || f !== 1'b0 || d !== 32'd0 || !w || sb) begin
         nerr++; $display("FAIL word_store: cyc=%0d fault=%b rdata=%h we=%b stallbad=%b want 4 0 0 1 0", cyc, f, d, w, sb);
      end
      do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 4 || f !== 1'b0 || d !== 32'hDEADBEEF || w || sb) begin
         nerr++; $display("FAIL word_load: cyc=%0d fault=%b rdata=%h we=%b stallbad=%b want 4 0 deadbeef 0 0", cyc, f, d, w, sb);
      end
   endtask

   task automatic test_byte_sign;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      do_req(0, 1'b1, 32'h21, 32'h12345680, 3'b000, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 4 || f !== 1'b0 || !w) begin
         nerr++; $display("FAIL byte_store: cyc=%0d fault=%b we=%b want 4 0 1", cyc, f, w);
      end
      do_req(0, 1'b0, 32'h21, 32'h0, 3'b000, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 4 || f !== 1'b0 || d !== 32'hFFFFFF80) begin
         nerr++; $display("FAIL byte_load_signed: cyc=%0d fault=%b rdata=%h want 4 0 ffffff80", cyc, f, d);
      end
      do_req(0, 1'b0, 32'h21, 32'h0, 3'b100, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 4 || f !== 1'b0 || d !== 32'h00000080) begin
         nerr++; $display("FAIL byte_load_unsigned: cyc=%0d fault=%b rdata=%h want 4 0 00000080", cyc, f, d);
      end
   endtask

   task automatic test_misaligned;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      do_req(0, 1'b1, 32'h02, 32'hA5A5A5A5, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 1 || f !== 1'b1 || w || sb) begin
         nerr++; $display("FAIL misaligned_word_store: cyc=%0d fault=%b we=%b stallbad=%b want 1 1 0 0", cyc, f, w, sb);
      end
      nvec++;
      if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h04030201) begin
         nerr++; $display("FAIL misaligned_mem: word0=%h want 04030201", {mem[3], mem[2], mem[1], mem[0]});
      end
      do_req(0, 1'b0, 32'h03, 32'h0, 3'b001, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 1 || f !== 1'b1 || d !== 32'd0) begin
         nerr++; $display("FAIL misaligned_half_load: cyc=%0d fault=%b rdata=%h want 1 1 0", cyc, f, d);
      end
   endtask

   task automatic test_out_of_range;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      // Preceding response held nonzero data; the fault must clear it.
      do_req(0, 1'b0, 32'h21, 32'h0, 3'b000, cyc, d, f, w, sb);
      do_req(0, 1'b0, 32'h80, 32'h0, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 1 || f !== 1'b1 || d !== 32'd0 || sb) begin
         nerr++; $display("FAIL out_of_range: cyc=%0d fault=%b rdata=%h stallbad=%b want 1 1 0 0", cyc, f, d, sb);
      end
   endtask

   task automatic test_reset_mid_store;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      bit bad;
      @(negedge clk);
      sel = 1;
      req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_ubhw = 3'b010;
      rv = 4'b0010;
      @(posedge clk);       // acceptance
      @(posedge clk);       // start of cycle 2 (WAIT)
      #1 rst = 1'b1;
      #1;
      nvec++;
      if (rdy[1] !== 1'b1 || rsv[1] !== 1'b0 || rwe[1] !== 1'b0) begin
         nerr++; $display("FAIL reset_mid_store_state: ready=%b valid=%b we=%b want 1 0 0", rdy[1], rsv[1], rwe[1]);
      end
      @(negedge clk);
      rv = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsv[1] !== 1'b0 || rwe[1] !== 1'b0) bad = 1'b1;
      end
      nvec++;
      if (bad) begin
         nerr++; $display("FAIL reset_mid_store_resp: got resp_valid/ram_we after abort, want none");
      end
      do_req(1, 1'b0, 32'h30, 32'h0, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 5 || f !== 1'b0 || d !== 32'h34333231) begin
         nerr++; $display("FAIL reset_mid_store_load: cyc=%0d fault=%b rdata=%h want 5 0 34333231", cyc, f, d);
      end
   endtask

   task automatic test_latency_sweep;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      do_req(2, 1'b0, 32'h10, 32'h0, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 2 || d !== 32'hDEADBEEF || sb) begin
         nerr++; $display("FAIL latency0: cyc=%0d rdata=%h stallbad=%b want 2 deadbeef 0", cyc, d, sb);
      end
      do_req(3, 1'b0, 32'h10, 32'h0, 3'b010, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 17 || d !== 32'hDEADBEEF || sb) begin
         nerr++; $display("FAIL latency15: cyc=%0d rdata=%h stallbad=%b want 17 deadbeef 0", cyc, d, sb);
      end
   endtask

   task automatic test_back_to_back;
      int cyc; logic [31:0] d; logic f; bit w; bit sb;
      // Half store then unsigned half load, issued with minimum spacing.
      do_req(2, 1'b1, 32'h40, 32'h0000BEEF, 3'b001, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 2 || f !== 1'b0 || !w) begin
         nerr++; $display("FAIL b2b_store: cyc=%0d fault=%b we=%b want 2 0 1", cyc, f, w);
      end
      do_req(2, 1'b0, 32'h40, 32'h0, 3'b101, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 2 || d !== 32'h0000BEEF) begin
         nerr++; $display("FAIL b2b_load_unsigned: cyc=%0d rdata=%h want 2 0000beef", cyc, d);
      end
      do_req(2, 1'b0, 32'h40, 32'h0, 3'b001, cyc, d, f, w, sb);
      nvec++;
      if (cyc != 2 || d !== 32'hFFFFBEEF) begin
         nerr++; $display("FAIL b2b_load_signed: cyc=%0d rdata=%h want 2 ffffbeef", cyc, d);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_word_store_load();
      test_byte_sign();
      test_misaligned();
      test_out_of_range();
      test_reset_mid_store();
      test_latency_sweep();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
